// File: rtl/fpu_muldiv_pkg.sv
// Shared types and default sizing for the FPU mantissa multiply/divide sequencer.
package fpu_muldiv_pkg;

   localparam int unsigned MANT_WIDTH = 23;
   localparam int unsigned EXP_WIDTH  = 8;
   localparam int unsigned PROD_W     = 2 * MANT_WIDTH + 2;
   localparam int unsigned MUL_ITERS  = MANT_WIDTH + 1;
   localparam int unsigned DIV_ITERS  = 2 * MANT_WIDTH + 1;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      MUL_ITER,
      DIV_ITER,
      DONE
   } state_t;

   typedef enum logic {
      OP_MUL,
      OP_DIV
   } op_t;

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration: shift-add multiply step (LSB first) or restoring divide step (MSB first).
module muldiv_iter_step
   import fpu_muldiv_pkg::*;
#(
   parameter int unsigned mant_width = MANT_WIDTH
) (
   input  op_t                       mode,
   input  logic [2*mant_width+1:0]   acc,
   input  logic [mant_width+1:0]     rem,
   input  logic [mant_width:0]       opnd,
   output logic [2*mant_width+1:0]   acc_next,
   output logic [mant_width+1:0]     rem_next
);

   localparam int unsigned MW = mant_width + 1;
   localparam int unsigned RW = mant_width + 2;
   localparam int unsigned PW = 2 * mant_width + 2;

   logic [RW-1:0] sum;
   logic [MW-1:0] diff;
   logic          q_bit;

   always_comb begin
      acc_next = acc;
      rem_next = rem;
      sum      = '0;
      diff     = '0;
      q_bit    = 1'b0;
      if (mode == OP_MUL) begin
         // Upper half accumulates the multiplicand; multiplier bits drain out of the low end.
         sum      = {1'b0, acc[PW-1 -: MW]} + (acc[0] ? {1'b0, opnd} : '0);
         acc_next = {sum, acc[MW-1:1]};
      end else begin
         q_bit    = (rem >= {1'b0, opnd});
         diff     = q_bit ? MW'(rem - {1'b0, opnd}) : MW'(rem);
         rem_next = {diff, 1'b0};
         acc_next = {acc[PW-2:0], q_bit};
      end
   end

endmodule

// File: rtl/fp_muldiv_sequencer.sv
// Iterative mantissa multiply/divide sequencer feeding the muldiv normaliser.
module fp_muldiv_sequencer
   import fpu_muldiv_pkg::*;
#(
   parameter int unsigned mant_width = MANT_WIDTH,
   parameter int unsigned exp_width  = EXP_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_is_div,
   input  logic [mant_width:0]       in_mant_a,
   input  logic [mant_width:0]       in_mant_b,
   input  logic [exp_width+1:0]      in_exp_a,
   input  logic [exp_width+1:0]      in_exp_b,
   input  logic                      flush,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [2*mant_width+1:0]   unnorm_mant,
   output logic [exp_width+1:0]      unnorm_exp,
   output logic                      div_by_zero
);

   localparam int unsigned MW    = mant_width + 1;
   localparam int unsigned RW    = mant_width + 2;
   localparam int unsigned PW    = 2 * mant_width + 2;
   localparam int unsigned EW    = exp_width + 2;
   localparam int unsigned N_MUL = mant_width + 1;
   localparam int unsigned N_DIV = 2 * mant_width + 1;
   localparam int unsigned CW    = $clog2(PW);

   state_t        state;
   state_t        state_next;
   op_t           op;
   logic [MW-1:0] opnd;
   logic [RW-1:0] rem;
   logic [CW-1:0] cnt;
   logic          accept;
   logic          divisor_zero;
   logic [PW-1:0] step_acc;
   logic [RW-1:0] step_rem;

   assign divisor_zero = (opnd == '0);

   muldiv_iter_step #(
      .mant_width (mant_width)
   ) u_step (
      .mode     (op),
      .acc      (unnorm_mant),
      .rem      (rem),
      .opnd     (opnd),
      .acc_next (step_acc),
      .rem_next (step_rem)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next state; flush overrides every transition including an accept.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            accept = in_valid && !flush;
            if (in_valid) state_next = in_is_div ? PREP : MUL_ITER;
         end
         PREP:     state_next = divisor_zero ? DONE : DIV_ITER;
         MUL_ITER,
         DIV_ITER: if (cnt == '0) state_next = DONE;
         DONE:     if (out_ready) state_next = IDLE;
         default:  state_next = IDLE;
      endcase
      if (flush) state_next = IDLE;
   end

   // Datapath; unnorm_mant doubles as the working accumulator/quotient register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         div_by_zero <= 1'b0;
         unnorm_mant <= '0;
         unnorm_exp  <= '0;
         cnt         <= '0;
         rem         <= '0;
         opnd        <= '0;
         op          <= OP_MUL;
      end else begin
         in_ready  <= (state_next == IDLE);
         out_valid <= (state_next == DONE);
         if (flush || state_next == IDLE)   div_by_zero <= 1'b0;
         else if (state == PREP && divisor_zero) div_by_zero <= 1'b1;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (in_is_div) begin
                     op          <= OP_DIV;
                     opnd        <= in_mant_b;
                     rem         <= {1'b0, in_mant_a};
                     unnorm_mant <= '0;
                     unnorm_exp  <= in_exp_a - in_exp_b;
                  end else begin
                     op          <= OP_MUL;
                     opnd        <= in_mant_a;
                     rem         <= '0;
                     unnorm_mant <= {{(PW-MW){1'b0}}, in_mant_b};
                     unnorm_exp  <= in_exp_a + in_exp_b;
                     cnt         <= CW'(N_MUL - 1);
                  end
               end
            end
            PREP: begin
               if (divisor_zero) begin
                  unnorm_mant <= '1;
               end else begin
                  cnt <= CW'(N_DIV - 1);
                  // Pre-scale so the leading quotient bit always lands at the binary point.
                  if (rem[MW-1:0] < opnd) begin
                     rem        <= {rem[MW-1:0], 1'b0};
                     unnorm_exp <= unnorm_exp - EW'(1);
                  end
               end
            end
            MUL_ITER,
            DIV_ITER: begin
               unnorm_mant <= step_acc;
               rem         <= step_rem;
               if (cnt != '0)
                  cnt <= cnt - CW'(1);
               else if (state == DIV_ITER)
                  unnorm_mant <= {step_acc[PW-1:1], step_acc[0] | (step_rem != '0)};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_muldiv_sequencer.sv
// Directed bench for fp_muldiv_sequencer with hand-computed mantissa, exponent and latency values.
module tb_fp_muldiv_sequencer;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_is_div;
   logic [23:0] in_mant_a;
   logic [23:0] in_mant_b;
   logic [9:0]  in_exp_a;
   logic [9:0]  in_exp_b;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [47:0] unnorm_mant;
   logic [9:0]  unnorm_exp;
   logic        div_by_zero;

   int n_cmp = 0;
   int n_err = 0;

   fp_muldiv_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_is_div   (in_is_div),
      .in_mant_a   (in_mant_a),
      .in_mant_b   (in_mant_b),
      .in_exp_a    (in_exp_a),
      .in_exp_b    (in_exp_b),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .unnorm_mant (unnorm_mant),
      .unnorm_exp  (unnorm_exp),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expected);
      n_cmp++;
      if (obs !== expected) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expected);
      end
   endtask

   task automatic check_zeroed(input string tag);
      check({tag, "_rdy"},  64'(in_ready),    64'(1));
      check({tag, "_ov"},   64'(out_valid),   64'(0));
      check({tag, "_mant"}, 64'(unnorm_mant), 64'(0));
      check({tag, "_exp"},  64'(unnorm_exp),  64'(0));
      check({tag, "_dbz"},  64'(div_by_zero), 64'(0));
   endtask

   // Called just after the accept edge; returns the cycle in which out_valid is first seen.
   task automatic wait_result(output int cyc);
      cyc = 1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (out_valid) break;
         @(posedge clk);
         cyc++;
      end
   endtask

   task automatic run_op(input string tag, input logic is_div,
                         input logic [23:0] a, input logic [23:0] b,
                         input logic [9:0] ea, input logic [9:0] eb,
                         input int lat, input logic [47:0] mant,
                         input logic [9:0] e, input logic dbz);
      int cyc;
      in_is_div = is_div;
      in_mant_a = a;
      in_mant_b = b;
      in_exp_a  = ea;
      in_exp_b  = eb;
      in_valid  = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      wait_result(cyc);
      check({tag, "_lat"},  64'(cyc),         64'(lat));
      check({tag, "_mant"}, 64'(unnorm_mant), 64'(mant));
      check({tag, "_exp"},  64'(unnorm_exp),  64'(e));
      check({tag, "_dbz"},  64'(div_by_zero), 64'(dbz));
      check({tag, "_rdy"},  64'(in_ready),    64'(0));
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hs_rdy"}, 64'(in_ready),    64'(1));
      check({tag, "_hs_ov"},  64'(out_valid),   64'(0));
      check({tag, "_hs_dbz"}, 64'(div_by_zero), 64'(0));
   endtask

   initial begin
      int          cyc;
      logic [47:0] held;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_is_div = 1'b0;
      in_mant_a = '0;
      in_mant_b = '0;
      in_exp_a  = '0;
      in_exp_b  = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_zeroed("reset");
      rst_n = 1'b1;

      run_op("mul_1p5sq", 1'b0, 24'hC00000, 24'hC00000, 10'd0, 10'd0, 25, 48'h900000000000, 10'd0, 1'b0);
      handshake("mul_1p5sq");
      run_op("mul_max", 1'b0, 24'hFFFFFF, 24'hFFFFFF, 10'h3FB, 10'h3FD, 25, 48'hFFFFFE000001, 10'h3F8, 1'b0);
      handshake("mul_max");
      run_op("mul_zero", 1'b0, 24'h000000, 24'hC00000, 10'd7, 10'd2, 25, 48'h0, 10'd9, 1'b0);
      handshake("mul_zero");
      run_op("div_2_3", 1'b1, 24'h800000, 24'hC00000, 10'd0, 10'd0, 49, 48'h555555555555, 10'h3FF, 1'b0);
      handshake("div_2_3");
      run_op("div_exact", 1'b1, 24'hC00000, 24'h800000, 10'd3, 10'h3FE, 49, 48'h600000000000, 10'd5, 1'b0);
      handshake("div_exact");
      run_op("div_max", 1'b1, 24'hFFFFFF, 24'h800000, 10'd0, 10'd0, 49, 48'h7FFFFF800000, 10'd0, 1'b0);
      handshake("div_max");
      run_op("div_zero_a", 1'b1, 24'h000000, 24'h800000, 10'd2, 10'd0, 49, 48'h0, 10'd1, 1'b0);
      handshake("div_zero_a");
      run_op("div_by_0", 1'b1, 24'hC00000, 24'h000000, 10'd4, 10'd1, 2, 48'hFFFFFFFFFFFF, 10'd3, 1'b1);
      handshake("div_by_0");

      // Backpressure: result must stay put while out_ready is low.
      out_ready = 1'b0;
      run_op("bp", 1'b0, 24'hA00000, 24'hC00000, 10'd2, 10'h3FF, 25, 48'h780000000000, 10'd1, 1'b0);
      held = unnorm_mant;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         @(negedge clk);
         check("bp_hold_mant", 64'(unnorm_mant), 64'(held));
         check("bp_hold_ov",   64'(out_valid),   64'(1));
         check("bp_hold_rdy",  64'(in_ready),    64'(0));
      end
      handshake("bp");

      // Flush in cycle 10 of a divide while a new request is already waiting.
      in_is_div = 1'b1;
      in_mant_a = 24'h800000;
      in_mant_b = 24'hC00000;
      in_exp_a  = 10'd0;
      in_exp_b  = 10'd0;
      in_valid  = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      flush     = 1'b1;
      in_valid  = 1'b1;
      in_is_div = 1'b0;
      in_mant_a = 24'hC00000;
      in_mant_b = 24'hC00000;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check("flush_rdy", 64'(in_ready),    64'(1));
      check("flush_ov",  64'(out_valid),   64'(0));
      check("flush_dbz", 64'(div_by_zero), 64'(0));
      @(posedge clk);
      #1 in_valid = 1'b0;
      wait_result(cyc);
      check("flush_next_lat",  64'(cyc),         64'(25));
      check("flush_next_mant", 64'(unnorm_mant), 64'(48'h900000000000));
      handshake("flush_next");

      // Reset in the middle of a multiply.
      in_is_div = 1'b0;
      in_mant_a = 24'hFFFFFF;
      in_mant_b = 24'hFFFFFF;
      in_exp_a  = 10'h3FB;
      in_exp_b  = 10'h3FD;
      in_valid  = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_zeroed("rst_mul");
      rst_n = 1'b1;

      // Reset while a divide-by-zero result is being held.
      out_ready = 1'b0;
      run_op("dbz_held", 1'b1, 24'h800000, 24'h000000, 10'd0, 10'd0, 2, 48'hFFFFFFFFFFFF, 10'd0, 1'b1);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_zeroed("rst_dbz");
      rst_n     = 1'b1;
      out_ready = 1'b1;

      run_op("recover", 1'b1, 24'hC00000, 24'h800000, 10'd3, 10'h3FE, 49, 48'h600000000000, 10'd5, 1'b0);
      handshake("recover");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
